// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
//   Sequencer and arbiter for the PC-source datapath of the multicycle CPU.
//   Arbitrates next-PC requests from main control (exc > rte > jmp > br > inc)
//   and drives the PC-source select together with the PC/EPC load pulses.
//   It also owns the multi-cycle exception sequence: save EPC, read the
//   handler vector from memory, then load the PC from that vector.
//
//   Parameters
//     MEM_LAT   cycles from vec_read assertion until vector data is valid (0..15)
//     BOOT_EN   1: one boot-vector PC load after reset, 0: start in IDLE
//
//   Ports
//     clk, reset      rising-edge clock, asynchronous active-high reset
//     inc_req         sequential fetch advance (PC <- PC+4)
//     br_req/br_taken branch resolved / branch condition
//     jmp_req         jump to jump target
//     rte_req         return from exception (PC <- EPC)
//     exc_req         exception raised, exc_cause selects the vector
//     pc_src          0 PC+4, 1 branch, 2 jump, 3 boot, 4 EPC, 5 mem vector
//     pc_write        PC load pulse
//     epc_write       EPC load pulse
//     vec_read        exception vector read in progress
//     vec_addr_sel    latched exception cause (vector address select)
//     busy            exception sequence in progress, requests ignored
//     double_fault    sticky, exc_req seen while busy; cleared by reset only
//
//   All outputs are registered; every request produces its effect in the
//   cycle after the edge that sampled it.
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
    parameter int unsigned MEM_LAT = 2,
    parameter bit          BOOT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_req,
    input  logic       br_req,
    input  logic       br_taken,
    input  logic       jmp_req,
    input  logic       rte_req,
    input  logic       exc_req,
    input  logic [1:0] exc_cause,
    output logic [2:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       vec_read,
    output logic [1:0] vec_addr_sel,
    output logic       busy,
    output logic       double_fault
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_EXC_SAVE,
        S_EXC_WAIT,
        S_EXC_LOAD
    } state_e;

    localparam logic [2:0] SRC_INC  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd2;
    localparam logic [2:0] SRC_BOOT = 3'd3;
    localparam logic [2:0] SRC_EPC  = 3'd4;
    localparam logic [2:0] SRC_VEC  = 3'd5;

    localparam logic [3:0] LAT       = 4'(MEM_LAT);
    localparam state_e     RST_STATE = BOOT_EN ? S_BOOT : S_IDLE;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] pc_src_q, pc_src_d;
    logic       pc_write_q, pc_write_d;
    logic       epc_write_q, epc_write_d;
    logic       vec_read_q, vec_read_d;
    logic [1:0] vec_addr_sel_q, vec_addr_sel_d;
    logic       busy_q, busy_d;
    logic       double_fault_q, double_fault_d;

    // Next-state and next-output logic. Pulses default to 0 each cycle so
    // pc_src returns to 0 whenever no PC load is being issued.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_src_d       = SRC_INC;
        pc_write_d     = 1'b0;
        epc_write_d    = 1'b0;
        vec_read_d     = 1'b0;
        busy_d         = 1'b0;
        vec_addr_sel_d = vec_addr_sel_q;
        double_fault_d = double_fault_q;

        // busy_q is high exactly while the exception sequence owns the PC.
        if (busy_q && exc_req) begin
            double_fault_d = 1'b1;
        end

        case (state_q)
            S_BOOT: begin
                // Requests sampled on this edge are intentionally dropped.
                state_d    = S_IDLE;
                pc_src_d   = SRC_BOOT;
                pc_write_d = 1'b1;
            end

            S_IDLE: begin
                if (exc_req) begin
                    state_d        = S_EXC_SAVE;
                    epc_write_d    = 1'b1;
                    vec_read_d     = 1'b1;
                    busy_d         = 1'b1;
                    // Reserved cause falls back to the invalid-opcode vector.
                    vec_addr_sel_d = (exc_cause == 2'd3) ? 2'd0 : exc_cause;
                end else if (rte_req) begin
                    pc_src_d   = SRC_EPC;
                    pc_write_d = 1'b1;
                end else if (jmp_req) begin
                    pc_src_d   = SRC_JMP;
                    pc_write_d = 1'b1;
                end else if (br_req && br_taken) begin
                    pc_src_d   = SRC_BR;
                    pc_write_d = 1'b1;
                end else if (inc_req) begin
                    // A not-taken branch falls through here so a concurrent
                    // fetch advance is still honoured.
                    pc_src_d   = SRC_INC;
                    pc_write_d = 1'b1;
                end
            end

            S_EXC_SAVE: begin
                vec_read_d = 1'b1;
                busy_d     = 1'b1;
                if (LAT == 4'd0) begin
                    state_d    = S_EXC_LOAD;
                    pc_src_d   = SRC_VEC;
                    pc_write_d = 1'b1;
                end else begin
                    state_d = S_EXC_WAIT;
                    cnt_d   = LAT;
                end
            end

            S_EXC_WAIT: begin
                // Counter holds the number of WAIT cycles left including this one.
                vec_read_d = 1'b1;
                busy_d     = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_EXC_LOAD;
                    cnt_d      = 4'd0;
                    pc_src_d   = SRC_VEC;
                    pc_write_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_EXC_LOAD: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RST_STATE;
            cnt_q          <= 4'd0;
            pc_src_q       <= SRC_INC;
            pc_write_q     <= 1'b0;
            epc_write_q    <= 1'b0;
            vec_read_q     <= 1'b0;
            vec_addr_sel_q <= 2'd0;
            busy_q         <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_src_q       <= pc_src_d;
            pc_write_q     <= pc_write_d;
            epc_write_q    <= epc_write_d;
            vec_read_q     <= vec_read_d;
            vec_addr_sel_q <= vec_addr_sel_d;
            busy_q         <= busy_d;
            double_fault_q <= double_fault_d;
        end
    end

    assign pc_src       = pc_src_q;
    assign pc_write     = pc_write_q;
    assign epc_write    = epc_write_q;
    assign vec_read     = vec_read_q;
    assign vec_addr_sel = vec_addr_sel_q;
    assign busy         = busy_q;
    assign double_fault = double_fault_q;

endmodule
